// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals for the program loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        In_Data;
    logic              In_Valid;
    logic              In_Ready;
    logic              Mem_WE;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_Data;

    // Stream source / memory observer side.
    modport master (
        output In_Data, In_Valid,
        input  In_Ready, Mem_WE, Mem_Addr, Mem_Data
    );

    // Loader side.
    modport slave (
        input  In_Data, In_Valid,
        output In_Ready, Mem_WE, Mem_Addr, Mem_Data
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: fills instruction memory, verifies the checksum
// and holds the CPU in clear until a complete, verified image is present.
module imem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    imem_loader_if.slave      bus,
    output logic              Cpu_Clrn,
    output logic              Done,
    output logic              Error,
    output logic [1:0]        Err_Code,
    output logic [ADDR_W:0]   Words_Loaded
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CAP   = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    logic [7:0]        sum;
    logic [7:0]        n_hi;
    logic [15:0]       n_words;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    logic              in_ready;
    logic              xfer;
    logic [15:0]       hdr_n;
    logic              len_bad;
    logic              last_word;

    // Ready depends on state alone so the source never sees a valid->ready loop.
    assign in_ready  = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign xfer      = bus.In_Valid && in_ready;
    assign hdr_n     = {n_hi, bus.In_Data};
    assign len_bad   = 32'(hdr_n) > CAP;
    assign last_word = (32'(Words_Loaded) + 32'd1) == 32'(n_words);

    assign bus.In_Ready = in_ready;
    assign bus.Mem_WE   = mem_we;
    assign bus.Mem_Addr = mem_addr;
    assign bus.Mem_Data = mem_data;

    // Loader FSM with registered memory-write and status outputs.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state        <= S_IDLE;
            sum          <= '0;
            n_hi         <= '0;
            n_words      <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            Cpu_Clrn     <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            Err_Code     <= 2'b00;
            Words_Loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (Start) begin
                        state        <= S_HDR_HI;
                        Done         <= 1'b0;
                        Error        <= 1'b0;
                        Cpu_Clrn     <= 1'b0;
                        Err_Code     <= 2'b00;
                        Words_Loaded <= '0;
                        sum          <= '0;
                        byte_cnt     <= '0;
                    end
                end
                S_HDR_HI: begin
                    if (xfer) begin
                        n_hi  <= bus.In_Data;
                        sum   <= sum + bus.In_Data;
                        state <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        n_words <= hdr_n;
                        sum     <= sum + bus.In_Data;
                        if (len_bad) begin
                            state    <= S_ERROR;
                            Error    <= 1'b1;
                            Err_Code <= 2'b01;
                        end else if (hdr_n == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        sum      <= sum + bus.In_Data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= Words_Loaded[ADDR_W-1:0];
                            mem_data     <= {asm_q, bus.In_Data};
                            Words_Loaded <= Words_Loaded + CNT_W'(1);
                            if (last_word) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            asm_q <= {asm_q[15:0], bus.In_Data};
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (bus.In_Data == sum) begin
                            state    <= S_DONE;
                            Done     <= 1'b1;
                            Cpu_Clrn <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            Error    <= 1'b1;
                            Err_Code <= 2'b10;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
